// File: rtl/cr_zigzag_serializer.sv
// Cr zigzag serializer: latches a 64-coefficient DCT block on a coeff_valid rising edge and streams it in JPEG zigzag order.
// Latency: first beat 1 cycle after the capture edge into an empty serializer; queued blocks follow with no bubble.
// Backpressure: beats hold while out_ready=0; two banks queue blocks, a third is dropped (sticky overflow). CR_ZZ_TRUNC_EN ends blocks at the last nonzero.
module cr_zigzag_serializer #(
    parameter int COEFF_W   = 11,
    parameter int NUM_COEFF = 64
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_COEFF*COEFF_W-1:0] coeff_in,
    input  logic                         coeff_valid,
    input  logic                         out_ready,
    output logic                         out_valid,
    output logic signed [COEFF_W-1:0]    coeff_out,
    output logic [5:0]                   out_index,
    output logic                         out_last,
    output logic                         busy,
    output logic                         overflow
);

    if (NUM_COEFF != 64) begin : g_bad_cfg
        $error("cr_zigzag_serializer: NUM_COEFF must be 64");
    end

    // Zigzag position -> raster index (r*8+c)
    localparam logic [5:0] ZZ [64] = '{
        6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
        6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
        6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
        6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
        6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
        6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
        6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
        6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
    };

    typedef enum logic {
        S_IDLE,
        S_STREAM
    } state_t;

    state_t     state, state_nxt;
    logic       cur, cur_nxt;       // bank being streamed: 0 = A, 1 = B
    logic [5:0] k, k_nxt;
    logic       cv_q;
    logic       full_a, full_b;
    logic       cap, hs;
    logic       rel_a, rel_b, free_a, free_b, wr_a, wr_b;
    logic [5:0] last_k;

    logic signed [COEFF_W-1:0] bank_a [NUM_COEFF];
    logic signed [COEFF_W-1:0] bank_b [NUM_COEFF];

    assign cap = coeff_valid & ~cv_q;
    assign hs  = out_valid & out_ready;

    // A bank finishing its final handshake this cycle is reusable by a simultaneous capture
    assign rel_a  = hs & out_last & ~cur;
    assign rel_b  = hs & out_last & cur;
    assign free_a = ~full_a | rel_a;
    assign free_b = ~full_b | rel_b;
    assign wr_a   = cap & free_a;
    assign wr_b   = cap & ~free_a & free_b;

    assign out_valid = (state == S_STREAM);
    assign out_index = k;
    assign out_last  = out_valid & (k == last_k);
    assign coeff_out = out_valid ? (cur ? bank_b[ZZ[k]] : bank_a[ZZ[k]]) : '0;
    assign busy      = full_a | full_b;

`ifdef CR_ZZ_TRUNC_EN
    logic [5:0] lnz_a, lnz_b, lnz_in;

    always_comb begin
        lnz_in = '0;
        for (int j = 0; j < NUM_COEFF; j++) begin
            if (coeff_in[int'(ZZ[j])*COEFF_W +: COEFF_W] != '0) begin
                lnz_in = 6'(j);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lnz_a <= '0;
            lnz_b <= '0;
        end else begin
            if (wr_a) lnz_a <= lnz_in;
            if (wr_b) lnz_b <= lnz_in;
        end
    end

    assign last_k = cur ? lnz_b : lnz_a;
`else
    assign last_k = 6'd63;
`endif

    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_COEFF; i++) begin
            if (wr_a) bank_a[i] <= coeff_in[i*COEFF_W +: COEFF_W];
            if (wr_b) bank_b[i] <= coeff_in[i*COEFF_W +: COEFF_W];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            cur      <= 1'b0;
            k        <= '0;
            cv_q     <= 1'b0;
            full_a   <= 1'b0;
            full_b   <= 1'b0;
            overflow <= 1'b0;
        end else begin
            state  <= state_nxt;
            cur    <= cur_nxt;
            k      <= k_nxt;
            cv_q   <= coeff_valid;
            full_a <= (full_a & ~rel_a) | wr_a;
            full_b <= (full_b & ~rel_b) | wr_b;
            if (cap & ~free_a & ~free_b) begin
                overflow <= 1'b1;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        cur_nxt   = cur;
        k_nxt     = k;
        case (state)
            S_IDLE: begin
                // A capture while idle always lands in bank A, so stream it straight away
                if (full_a || wr_a) begin
                    state_nxt = S_STREAM;
                    cur_nxt   = 1'b0;
                    k_nxt     = '0;
                end else if (full_b) begin
                    state_nxt = S_STREAM;
                    cur_nxt   = 1'b1;
                    k_nxt     = '0;
                end
            end
            S_STREAM: begin
                if (hs) begin
                    if (out_last) begin
                        k_nxt = '0;
                        if (cur ? full_a : full_b) begin
                            cur_nxt = ~cur;
                        end else begin
                            state_nxt = S_IDLE;
                        end
                    end else begin
                        k_nxt = k + 6'd1;
                    end
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_cr_zigzag_serializer.sv
// Bench for cr_zigzag_serializer: block-queue model of captures/drains plus directed literal checks.
module tb_cr_zigzag_serializer;
    localparam int W  = 11;
    localparam int N  = 64;
    localparam int BW = N * W;
    typedef logic [BW-1:0] blk_t;

    logic                clk = 1'b0;
    logic                rst;
    blk_t                coeff_in;
    logic                coeff_valid;
    logic                out_ready;
    logic                out_valid;
    logic signed [W-1:0] coeff_out;
    logic [5:0]          out_index;
    logic                out_last;
    logic                busy;
    logic                overflow;

    cr_zigzag_serializer #(.COEFF_W(W), .NUM_COEFF(N)) dut (
        .clk(clk), .rst(rst), .coeff_in(coeff_in), .coeff_valid(coeff_valid),
        .out_ready(out_ready), .out_valid(out_valid), .coeff_out(coeff_out),
        .out_index(out_index), .out_last(out_last), .busy(busy), .overflow(overflow)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;
    int cap_cyc = 0;
    int zz [64];

    // model state
    blk_t blkq [$];
    int   lastq [$];
    int   beat = 0;
    bit   prev_cv = 0, ovf_m = 0, bubble = 0, model_ok = 0, just_reset = 0, prev_stall = 0;
    logic signed [31:0] prev_dat, prev_idx, prev_last;

    int seen_dat [$], seen_idx [$], seen_last [$], seen_cyc [$];
    bit rand_rdy = 0;

    blk_t b, b1, b2, b3;
    int   bad, n;

    task automatic chk(input string nm, input logic signed [31:0] act, input logic signed [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Zigzag order derived by walking anti-diagonals, alternating direction
    function automatic void build_zz();
        int j, lo, hi;
        j = 0;
        for (int s = 0; s < 15; s++) begin
            lo = (s > 7) ? s - 7 : 0;
            hi = (s < 7) ? s : 7;
            if (s % 2 == 1) begin
                for (int r = lo; r <= hi; r++) begin zz[j] = r * 8 + (s - r); j++; end
            end else begin
                for (int r = hi; r >= lo; r--) begin zz[j] = r * 8 + (s - r); j++; end
            end
        end
    endfunction

    function automatic int coef(input blk_t bb, input int raster);
        logic signed [W-1:0] v;
        v = bb[raster*W +: W];
        return int'(v);
    endfunction

    function automatic int model_last(input blk_t bb);
        int l;
        l = 63;
`ifdef CR_ZZ_TRUNC_EN
        l = 0;
        for (int j = 0; j < 64; j++) if (coef(bb, zz[j]) != 0) l = j;
`endif
        return l;
    endfunction

    function automatic blk_t rand_blk(input bit force_tail);
        blk_t r;
        for (int i = 0; i < N; i++)
            r[i*W +: W] = ($urandom_range(0, 2) == 0) ? '0 : W'($urandom_range(0, 2047));
        if (force_tail) r[63*W +: W] = W'($urandom_range(1, 2047));
        return r;
    endfunction

    task automatic seen_clear();
        seen_dat.delete(); seen_idx.delete(); seen_last.delete(); seen_cyc.delete();
    endtask

    task automatic send_block(input blk_t bb, input int hold);
        @(posedge clk); #2;
        coeff_in    = bb;
        coeff_valid = 1'b1;
        repeat (hold) @(posedge clk);
        #2 coeff_valid = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int w;
        w = 0;
        while ((blkq.size() != 0 || busy !== 1'b0) && w < budget) begin
            @(negedge clk); #1;
            w++;
        end
        chk("drain_in_time", 32'(w < budget), 1);
    endtask

    // Compare process: checks outputs against the block-queue model, then advances it
    always @(negedge clk) begin
        bit hs, fin, cap;
        int sz;
        cyc++;
        if (model_ok) begin
            if (just_reset) begin
                chk("rst_index", 32'(out_index), 0);
                chk("rst_coeff", 32'(coeff_out), 0);
                chk("rst_last", 32'(out_last), 0);
            end
            chk("busy", 32'(busy), 32'(blkq.size() != 0));
            chk("overflow", 32'(overflow), 32'(ovf_m));
            if (!bubble) chk("out_valid", 32'(out_valid), 32'(blkq.size() != 0));
            if (prev_stall) begin
                chk("stall_hold_valid", 32'(out_valid), 1);
                chk("stall_hold_dat", 32'(coeff_out), prev_dat);
                chk("stall_hold_idx", 32'(out_index), prev_idx);
                chk("stall_hold_last", 32'(out_last), prev_last);
            end
            if (out_valid === 1'b1 && blkq.size() != 0) begin
                chk("coeff_out", 32'(coeff_out), coef(blkq[0], zz[beat]));
                chk("out_index", 32'(out_index), beat);
                chk("out_last", 32'(out_last), 32'(beat == lastq[0]));
            end
        end
        just_reset = 0;
        if (rst) begin
            blkq.delete(); lastq.delete();
            beat = 0; prev_cv = 0; ovf_m = 0; bubble = 0; prev_stall = 0;
            model_ok = 1; just_reset = 1;
        end else if (model_ok) begin
            sz  = blkq.size();
            hs  = (out_valid === 1'b1) && (out_ready === 1'b1) && sz != 0;
            fin = hs && beat == lastq[0];
            cap = (coeff_valid === 1'b1) && !prev_cv;
            bubble = 0;
            if (hs) begin
                seen_dat.push_back(int'(coeff_out));
                seen_idx.push_back(int'(out_index));
                seen_last.push_back(int'(out_last));
                seen_cyc.push_back(cyc);
            end
            prev_stall = (out_valid === 1'b1) && (out_ready !== 1'b1);
            prev_dat   = 32'(coeff_out);
            prev_idx   = 32'(out_index);
            prev_last  = 32'(out_last);
            if (fin) begin
                void'(blkq.pop_front());
                void'(lastq.pop_front());
                beat = 0;
            end else if (hs) begin
                beat++;
            end
            if (cap) begin
                cap_cyc = cyc;
                if (sz - (fin ? 1 : 0) < 2) begin
                    blkq.push_back(coeff_in);
                    lastq.push_back(model_last(coeff_in));
                    // freed bank refilled while the other is empty: serializer passes through idle once
                    bubble = fin && sz == 1;
                end else begin
                    ovf_m = 1;
                end
            end
            prev_cv = coeff_valid;
        end
    end

    initial forever begin
        @(posedge clk); #1;
        if (rand_rdy) out_ready = 1'($urandom_range(0, 1));
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        build_zz();
        rst = 1'b1; coeff_valid = 1'b0; coeff_in = '0; out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;
        @(posedge clk); #2;
        chk("reset_out_valid", 32'(out_valid), 0);
        chk("reset_busy", 32'(busy), 0);
        chk("reset_overflow", 32'(overflow), 0);
        chk("reset_coeff_out", 32'(coeff_out), 0);

        // Ramp block, no stall
        out_ready = 1'b1;
        for (int i = 0; i < N; i++) b[i*W +: W] = W'(i);
        seen_clear();
        send_block(b, 1);
        wait_idle(300);
        chk("ramp_beats", seen_dat.size(), 64);
        if (seen_dat.size() == 64) begin
            chk("ramp_latency", seen_cyc[0] - cap_cyc, 1);
            chk("ramp_zz0", seen_dat[0], 0);
            chk("ramp_zz2", seen_dat[2], 8);
            chk("ramp_zz3", seen_dat[3], 16);
            chk("ramp_zz4", seen_dat[4], 9);
            chk("ramp_zz10", seen_dat[10], 32);
            chk("ramp_zz35", seen_dat[35], 56);
            chk("ramp_zz63", seen_dat[63], 63);
            chk("ramp_contiguous", seen_cyc[63] - seen_cyc[0], 63);
            bad = 0; n = 0;
            for (int i = 0; i < 64; i++) begin
                if (seen_idx[i] != i) bad++;
                n += seen_last[i];
            end
            chk("ramp_index_seq", bad, 0);
            chk("ramp_last_count", n, 1);
            chk("ramp_last_at_63", seen_last[63], 1);
        end

        // Signed extremes
        b = '0;
        b[0 +: W]    = 11'h400;
        b[63*W +: W] = 11'h3FF;
        seen_clear();
        send_block(b, 1);
        wait_idle(300);
        chk("neg_beats", seen_dat.size(), 64);
        if (seen_dat.size() == 64) begin
            chk("neg_dc", seen_dat[0], -1024);
            chk("neg_mid", seen_dat[1], 0);
            chk("neg_tail", seen_dat[63], 1023);
        end

        // Pseudorandom backpressure
        b = rand_blk(1);
        seen_clear();
        rand_rdy = 1;
        send_block(b, 1);
        wait_idle(1000);
        rand_rdy = 0; out_ready = 1'b1;
        chk("bp_beats", seen_dat.size(), 64);
        if (seen_dat.size() == 64) begin
            bad = 0;
            for (int i = 0; i < 64; i++) if (seen_dat[i] != coef(b, zz[i])) bad++;
            chk("bp_sequence", bad, 0);
        end

        // Three captures while stalled: third dropped
        out_ready = 1'b0;
        b1 = rand_blk(1); b2 = rand_blk(1); b3 = rand_blk(1);
        seen_clear();
        send_block(b1, 1); repeat (8) @(posedge clk);
        send_block(b2, 1); repeat (8) @(posedge clk);
        send_block(b3, 1);
        repeat (3) @(posedge clk); #2;
        chk("ovf_set", 32'(overflow), 1);
        chk("ovf_busy", 32'(busy), 1);
        chk("ovf_no_beats", seen_dat.size(), 0);
        repeat (5) @(posedge clk); #2;
        chk("ovf_sticky", 32'(overflow), 1);
        out_ready = 1'b1;
        wait_idle(500);
        chk("ovf_beats", seen_dat.size(), 128);
        if (seen_dat.size() == 128) begin
            chk("ovf_contiguous", seen_cyc[127] - seen_cyc[0], 127);
            bad = 0;
            for (int i = 0; i < 64; i++) begin
                if (seen_dat[i] != coef(b1, zz[i])) bad++;
                if (seen_dat[64+i] != coef(b2, zz[i])) bad++;
            end
            chk("ovf_order", bad, 0);
        end
        chk("ovf_sticky_after", 32'(overflow), 1);

        // coeff_valid held for 5 cycles
        for (int i = 0; i < N; i++) b[i*W +: W] = W'(i);
        seen_clear();
        send_block(b, 5);
        wait_idle(300);
        repeat (10) @(posedge clk); #2;
        chk("held_beats", seen_dat.size(), 64);
        chk("held_busy_after", 32'(busy), 0);

        // Reset at beat 30
        b = rand_blk(1);
        seen_clear();
        send_block(b, 1);
        n = 0;
        while (seen_dat.size() < 30 && n < 300) begin @(negedge clk); #1; n++; end
        chk("rst30_reached", seen_dat.size(), 30);
        @(posedge clk); #2;
        rst = 1'b1;
        @(posedge clk); #2;
        chk("rst30_valid", 32'(out_valid), 0);
        chk("rst30_busy", 32'(busy), 0);
        chk("rst30_overflow", 32'(overflow), 0);
        rst = 1'b0;
        for (int i = 0; i < N; i++) b[i*W +: W] = W'(i);
        seen_clear();
        send_block(b, 1);
        wait_idle(300);
        chk("post_rst_beats", seen_dat.size(), 64);
        if (seen_dat.size() == 64) begin
            chk("post_rst_idx0", seen_idx[0], 0);
            chk("post_rst_dat2", seen_dat[2], 8);
            chk("post_rst_dat63", seen_dat[63], 63);
        end

        // Randomized traffic checked by the compare process
        rand_rdy = 1;
        for (int t = 0; t < 14; t++) begin
            b = rand_blk(1'($urandom_range(0, 1)));
            send_block(b, $urandom_range(1, 3));
            repeat ($urandom_range(0, 90)) @(posedge clk);
        end
        wait_idle(3000);
        rand_rdy = 0; out_ready = 1'b1;

`ifdef CR_ZZ_TRUNC_EN
        b = '0;
        b[0 +: W]   = 11'd50;
        b[8*W +: W] = 11'h7FD;
        seen_clear();
        send_block(b, 1);
        wait_idle(300);
        chk("trunc_beats", seen_dat.size(), 3);
        if (seen_dat.size() == 3) begin
            chk("trunc_dc", seen_dat[0], 50);
            chk("trunc_b1", seen_dat[1], 0);
            chk("trunc_b2", seen_dat[2], -3);
            chk("trunc_last", seen_last[2], 1);
        end
        b = '0;
        seen_clear();
        send_block(b, 1);
        wait_idle(300);
        chk("zero_beats", seen_dat.size(), 1);
        if (seen_dat.size() == 1) begin
            chk("zero_dc", seen_dat[0], 0);
            chk("zero_last", seen_last[0], 1);
        end
`endif

        repeat (5) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/cr_zigzag_serializer.md
Name: cr_zigzag_serializer

Overview:
- Consumer of the Cr DCT output.
- Captures the 64 parallel signed coefficients when the DCT signals completion, and streams them one per beat in JPEG zigzag order over a valid/ready interface.
- Feeds the downstream Cr quantizer/entropy stage.
- Double-buffered, so the next block can be captured while the current block drains.

Parameters:
- COEFF_W, 11, coefficient width in bits (signed, two's complement).
- NUM_COEFF, 64, coefficients per block. Fixed at 64; any other value is a configuration error.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- coeff_in  input  NUM_COEFF*COEFF_W  raster-ordered block. Z[r][c] (r = row 0..7, c = column 0..7) occupies bits [(r*8+c)*COEFF_W +: COEFF_W]. Z[0][0] is the DCT's Z11_final.
- coeff_valid  input  1  the DCT output_enable; may be held high for multiple cycles.
- out_ready  input  1  downstream can accept a beat.
- out_valid  output  1  a coefficient beat is presented.
- coeff_out  output  COEFF_W  coefficient, signed.
- out_index  output  6  zigzag position 0..63 of coeff_out.
- out_last  output  1  final beat of the block.
- busy  output  1  at least one bank is occupied.
- overflow  output  1  sticky: a block was dropped.

Behaviour:
- Reset (synchronous): out_valid=0, coeff_out=0, out_index=0, out_last=0, busy=0, overflow=0, both banks empty, edge-detect register=0.
- Capture is triggered by a rising edge of coeff_valid: coeff_valid=1 and the registered previous value =0. A level held high yields exactly one capture.
- Two banks A/B with full flags. On a capture edge the block is written into a free bank; A is preferred when both are free.
- If a bank frees on the same cycle (final handshake of the streaming block), that bank counts as free and the capture is accepted.
- If both banks are full on a capture edge, the block is dropped, overflow is set and stays set until rst, and the banks are unaffected.
- FSM:
  - IDLE: out_valid=0. When any bank is full, load read pointer k=0, select the oldest full bank, go to STREAM.
  - STREAM: present coeff_out = bank[ZZ[k]], out_index=k, out_valid=1.
  - On out_valid&&out_ready: if out_last, clear that bank. Then go to STREAM on the other bank with k=0 if it is full, else go to IDLE. Otherwise k=k+1.
- Zigzag table ZZ[0..63] = 0,1,8,16,9,2,3,10,17,24,32,25,18,11,4,5,12,19,26,33,40,48,41,34,27,20,13,6,7,14,21,28,35,42,49,56,57,50,43,36,29,22,15,23,30,37,44,51,58,59,52,45,38,31,39,46,53,60,61,54,47,55,62,63. Entries are raster indices r*8+c.
- Latency: capture edge at cycle N with both banks empty → out_valid=1, out_index=0 at N+1.
- Back-to-back blocks drain with no bubble: index 63 of block 0 is followed by index 0 of block 1 on the next cycle.
- Handshake: while out_valid=1 and out_ready=0, coeff_out, out_index and out_last hold stable. out_valid never drops without a handshake, except on rst.
- out_last = (k==63), or k==last_nz when the optional feature is enabled.
- busy = fullA | fullB.
- Coefficient values pass through unmodified. No arithmetic; sign is preserved.
- Reset mid-stream: the stream aborts immediately and both banks are discarded.

Optional Feature:
- Macro: CR_ZZ_TRUNC_EN.
- Defined:
  - At capture, compute last_nz, the highest zigzag index with a nonzero coefficient (0 if all AC and the DC are zero), and store it per bank.
  - The stream ends after index last_nz; out_last is asserted on that beat.
  - The DC beat (index 0) is always sent.
- Undefined: every block streams exactly 64 beats. No last_nz logic is generated.

Test Plan:
- Ramp block Z[r][c]=r*8+c, out_ready=1 → 64 beats on consecutive cycles. coeff_out equals the ZZ table (0,1,8,16,9,...,63) and out_index=0..63. out_last only at 63. out_valid rises 1 cycle after the capture edge.
- Negative values: Z[0][0]=-1024, Z[7][7]=1023, all others 0 → beat 0 = -1024, beat 63 = 1023, and sign is intact at 11 bits.
- Backpressure: toggle out_ready on a pseudorandom pattern → outputs are held stable while stalled; the sequence equals the no-stall case; the beat count is 64.
- Three capture edges 10 cycles apart with out_ready=0 → blocks 1 and 2 are stored and block 3 is dropped. overflow=1 and stays 1. After releasing out_ready, exactly 128 beats are seen, with no gap between the blocks.
- coeff_valid held high for 5 cycles → exactly one block (64 beats) is emitted.
- rst asserted at beat 30 → the next cycle shows out_valid=0 and busy=0. A new block then streams correctly from index 0.
- With CR_ZZ_TRUNC_EN: Z[0][0]=50, Z[1][0]=-3 (zigzag index 2), others 0 → 3 beats (50, 0, -3) with out_last on index 2. An all-zero block → 1 beat (0) with out_last=1.
